piece_queue: RTL and testbench
==============================

# piece_queue

Consumer end of the block-generator interface. Pops generated blocks (shape, rotation, position) over a valid/ready handshake, buffers them in a small preview FIFO, and delivers the active piece to the game-control FSM on a spawn request. Sits between the block generator and the playfield/game-state logic. It also exposes the next-piece preview and an optional hold slot.

## Interface
- QDEPTH, 3, preview FIFO depth in entries (2..7)
- SPAWN_POS, 8'd128, position loaded with a held piece on swap
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- gen_valid  in  1  generator has a block on gen_*
- gen_shape  in  4  block shape, legal 0..6
- gen_rot  in  2  rotation 0..3 (0/90/180/270)
- gen_pos  in  8  spawn position
- gen_ready  out  1  queue accepts a block this cycle
- spawn_req  in  1  one-cycle pulse from game FSM: load next active piece
- hold_req  in  1  one-cycle pulse: hold/swap active piece (HOLD_EN only)
- spawn_ack  out  1  one-cycle pulse: act_* updated
- act_valid  out  1  act_* holds a live piece
- act_shape  out  4  active piece shape
- act_rot  out  2  active piece rotation
- act_pos  out  8  active piece position
- next_valid  out  1  queue non-empty
- next_shape  out  4  shape at queue head (preview)
- hold_valid  out  1  hold slot occupied
- hold_shape  out  4  held shape
- q_count  out  $clog2(QDEPTH+1)  entries in queue
- err_shape  out  1  sticky: illegal shape (>6) received

## Operation
- Queue: circular buffer, QDEPTH entries of {shape[3:0], rot[1:0], pos[7:0]}, rd/wr pointers wrap at QDEPTH-1 → 0.
- gen_ready = (q_count < QDEPTH), combinational; 0 while reset asserted.
- Push on gen_valid && gen_ready. If gen_shape > 6: handshake completes, entry discarded, err_shape set (cleared only by reset).
- States: IDLE, WAIT.
- IDLE, spawn_req, queue non-empty → pop head into act_*, act_valid=1, spawn_ack=1, clear hold_used; stay IDLE.
- IDLE, spawn_req, queue empty → WAIT (request pending).
- WAIT: when q_count > 0 → pop, load act_*, spawn_ack, → IDLE. spawn_req/hold_req in WAIT ignored.
- No bypass: a block pushed at edge k is poppable at edge k+1 at the earliest.
- Simultaneous push and pop: both occur, q_count unchanged; full queue with pop: gen_ready stays 0 that cycle (no push-through).
- spawn_req and hold_req same cycle: spawn wins, hold ignored.
- Outputs next_shape = head shape when next_valid, else 0.

## Timing
- Reset values: act_valid 0, act_shape 0, act_rot 0, act_pos SPAWN_POS, spawn_ack 0, queue empty, q_count 0, next_valid 0, next_shape 0, hold_valid 0, hold_shape 0, err_shape 0, state IDLE, hold_used 0.
- gen_ready high in the first cycle after reset deasserts.
- spawn_req sampled at edge k, queue non-empty → act_* and spawn_ack registered at edge k; spawn_ack high exactly one cycle.
- Empty queue: spawn_ack at the edge after the first push lands (push at edge k → ack at k+1).
- Reset mid-operation: everything returns to reset values immediately; pending WAIT request lost.

## Configuration
- HOLD_PIECE_EN defined: hold_req honoured in IDLE when act_valid && !hold_used. Hold empty → act shape to hold, hold_valid=1, then same as a spawn (pop queue; empty → WAIT), spawn_ack pulses on load. Hold occupied → swap in one cycle: act_shape=hold_shape, act_rot=0, act_pos=SPAWN_POS, hold_shape=old act_shape, spawn_ack pulses. Either case sets hold_used. hold_req with hold_used=1 or act_valid=0 ignored.
- Not defined: hold_req ignored, hold_valid and hold_shape tied 0, no hold storage.

## Test plan
- Reset, gen_valid=1 shapes 1,2,3,4 back-to-back (QDEPTH=3) → gen_ready=1,1,1,0; q_count=3; 4th not accepted until a spawn; next_shape=1.
- Queue {1,2,3}, spawn_req pulse → same edge act_shape=1, spawn_ack one cycle, q_count=2, next_shape=2; fill/pop 10 times to exercise pointer wrap, order preserved.
- Empty queue, spawn_req → no ack; push shape 5 at edge k → spawn_ack and act_shape=5 at edge k+1, q_count=0.
- Push gen_shape=7 → gen_ready handshake completes, q_count unchanged, err_shape=1 and stays 1 until reset.
- HOLD_PIECE_EN: active 2, queue {4,...}, hold_req → hold_shape=2, act_shape=4; second hold_req → ignored; spawn_req then hold_req → act_shape=2, act_rot=0, act_pos=128, hold_shape=previous active.
- Assert reset while in WAIT with q_count=2 → all outputs at reset values immediately, no spawn_ack after release.

Source files
------------

// File: rtl/piece_queue.sv
// piece_queue: consumer end of the block-generator interface.
//
// Blocks offered on gen_* are accepted over a valid/ready handshake into a small circular
// preview FIFO. When the game FSM pulses spawn_req, the head entry is popped into act_*. If
// the FIFO is empty, the request waits for the next block and is then served. The queue head
// is exposed as a preview on next_*. Blocks with an illegal shape (>6) still complete the
// handshake, but they are discarded and the sticky err_shape flag is set.
//
// Optional feature: define HOLD_PIECE_EN to enable the hold/swap slot driven by hold_req.
// When it is not defined, hold_req is ignored and hold_valid/hold_shape are tied to 0.
//
// Parameters
//   QDEPTH     preview FIFO depth in entries (2..7)
//   SPAWN_POS  position given to a piece swapped in from the hold slot
// Ports
//   clk, reset                        clock, asynchronous active-high reset
//   gen_valid/shape/rot/pos, gen_ready  generator handshake
//   spawn_req, hold_req               one-cycle request pulses from the game FSM
//   spawn_ack                         one-cycle pulse: act_* was just loaded
//   act_valid/shape/rot/pos           active piece
//   next_valid, next_shape            queue-head preview (shape 0 when empty)
//   hold_valid, hold_shape            hold slot
//   q_count                           number of queued entries
//   err_shape                         sticky illegal-shape flag
module piece_queue #(
  parameter int unsigned QDEPTH    = 3,
  parameter logic [7:0]  SPAWN_POS = 8'd128
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        gen_valid,
  input  logic [3:0]                  gen_shape,
  input  logic [1:0]                  gen_rot,
  input  logic [7:0]                  gen_pos,
  output logic                        gen_ready,
  input  logic                        spawn_req,
  input  logic                        hold_req,
  output logic                        spawn_ack,
  output logic                        act_valid,
  output logic [3:0]                  act_shape,
  output logic [1:0]                  act_rot,
  output logic [7:0]                  act_pos,
  output logic                        next_valid,
  output logic [3:0]                  next_shape,
  output logic                        hold_valid,
  output logic [3:0]                  hold_shape,
  output logic [$clog2(QDEPTH+1)-1:0] q_count,
  output logic                        err_shape
);

  localparam int unsigned CntW = $clog2(QDEPTH + 1);
  localparam int unsigned PtrW = $clog2(QDEPTH);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  typedef struct packed {
    logic [3:0] shape;
    logic [1:0] rot;
    logic [7:0] pos;
  } entry_t;

  entry_t          mem_q [QDEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [0:0]      state_q, state_d;
  logic            push, push_keep, pop, q_nonempty;
  entry_t          head;
  logic            err_q;

  logic            spawn_ack_q, spawn_ack_d;
  logic            act_valid_q, act_valid_d;
  logic [3:0]      act_shape_q, act_shape_d;
  logic [1:0]      act_rot_q, act_rot_d;
  logic [7:0]      act_pos_q, act_pos_d;

`ifdef HOLD_PIECE_EN
  logic            hold_valid_q, hold_valid_d;
  logic [3:0]      hold_shape_q, hold_shape_d;
  // Set once a hold has been used for the current piece; cleared by a normal spawn.
  logic            hold_used_q, hold_used_d;
`else
  logic            unused_hold_req;
  assign unused_hold_req = hold_req;
`endif

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(QDEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Readiness depends only on the registered count, so a full queue stays closed even in a
  // cycle that pops.
  assign gen_ready  = !reset && (count_q != CntW'(QDEPTH));
  assign push       = gen_valid && gen_ready;
  assign push_keep  = push && (gen_shape <= 4'd6);
  assign q_nonempty = (count_q != '0);
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    spawn_ack_d = 1'b0;
    act_valid_d = act_valid_q;
    act_shape_d = act_shape_q;
    act_rot_d   = act_rot_q;
    act_pos_d   = act_pos_q;
`ifdef HOLD_PIECE_EN
    hold_valid_d = hold_valid_q;
    hold_shape_d = hold_shape_q;
    hold_used_d  = hold_used_q;
`endif
    case (state_q)
      StIdle: begin
        if (spawn_req) begin
`ifdef HOLD_PIECE_EN
          hold_used_d = 1'b0;
`endif
          if (q_nonempty) pop = 1'b1;
          else            state_d = StWait;
        end
`ifdef HOLD_PIECE_EN
        else if (hold_req && act_valid_q && !hold_used_q) begin
          hold_used_d  = 1'b1;
          hold_shape_d = act_shape_q;
          if (hold_valid_q) begin
            // Swap: the held piece re-enters at the spawn point, unrotated.
            act_shape_d = hold_shape_q;
            act_rot_d   = '0;
            act_pos_d   = SPAWN_POS;
            spawn_ack_d = 1'b1;
          end else begin
            // Park the active piece and fetch a fresh one like a spawn.
            hold_valid_d = 1'b1;
            act_valid_d  = 1'b0;
            if (q_nonempty) pop = 1'b1;
            else            state_d = StWait;
          end
        end
`endif
      end
      StWait: begin
        if (q_nonempty) begin
          pop     = 1'b1;
          state_d = StIdle;
        end
      end
    endcase
    if (pop) begin
      act_valid_d = 1'b1;
      act_shape_d = head.shape;
      act_rot_d   = head.rot;
      act_pos_d   = head.pos;
      spawn_ack_d = 1'b1;
    end
  end

  always_comb begin
    case ({push_keep, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_keep) mem_q[wr_ptr_q] <= '{shape: gen_shape, rot: gen_rot, pos: gen_pos};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= StIdle;
      err_q       <= 1'b0;
      spawn_ack_q <= 1'b0;
      act_valid_q <= 1'b0;
      act_shape_q <= '0;
      act_rot_q   <= '0;
      act_pos_q   <= SPAWN_POS;
    end else begin
      if (push_keep) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)       rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && (gen_shape > 4'd6)) err_q <= 1'b1;
      count_q     <= count_d;
      state_q     <= state_d;
      spawn_ack_q <= spawn_ack_d;
      act_valid_q <= act_valid_d;
      act_shape_q <= act_shape_d;
      act_rot_q   <= act_rot_d;
      act_pos_q   <= act_pos_d;
    end
  end

`ifdef HOLD_PIECE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      hold_shape_q <= '0;
      hold_used_q  <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_shape_q <= hold_shape_d;
      hold_used_q  <= hold_used_d;
    end
  end

  assign hold_valid = hold_valid_q;
  assign hold_shape = hold_shape_q;
`else
  assign hold_valid = 1'b0;
  assign hold_shape = '0;
`endif

  assign spawn_ack  = spawn_ack_q;
  assign act_valid  = act_valid_q;
  assign act_shape  = act_shape_q;
  assign act_rot    = act_rot_q;
  assign act_pos    = act_pos_q;
  assign next_valid = q_nonempty;
  assign next_shape = q_nonempty ? head.shape : '0;
  assign q_count    = count_q;
  assign err_shape  = err_q;

endmodule

// File: tb/tb_piece_queue.sv
// Self-checking bench for piece_queue: directed scenarios plus random traffic. A reference
// model (a plain queue plus a pending-request flag) predicts every spawn_ack. A negedge
// monitor compares the predictions against the DUT.
module tb_piece_queue;

  localparam int unsigned QDEPTH = 3;

  typedef struct packed {
    logic [3:0] shape;
    logic [1:0] rot;
    logic [7:0] pos;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       gen_valid, gen_ready;
  logic [3:0] gen_shape;
  logic [1:0] gen_rot;
  logic [7:0] gen_pos;
  logic       spawn_req, hold_req, spawn_ack;
  logic       act_valid, next_valid, hold_valid, err_shape;
  logic [3:0] act_shape, next_shape, hold_shape;
  logic [1:0] act_rot;
  logic [7:0] act_pos;
  logic [1:0] q_count;

  piece_queue #(.QDEPTH(QDEPTH), .SPAWN_POS(8'd128)) dut (
    .clk        (clk),
    .reset      (reset),
    .gen_valid  (gen_valid),
    .gen_shape  (gen_shape),
    .gen_rot    (gen_rot),
    .gen_pos    (gen_pos),
    .gen_ready  (gen_ready),
    .spawn_req  (spawn_req),
    .hold_req   (hold_req),
    .spawn_ack  (spawn_ack),
    .act_valid  (act_valid),
    .act_shape  (act_shape),
    .act_rot    (act_rot),
    .act_pos    (act_pos),
    .next_valid (next_valid),
    .next_shape (next_shape),
    .hold_valid (hold_valid),
    .hold_shape (hold_shape),
    .q_count    (q_count),
    .err_shape  (err_shape)
  );

  always #5 clk = ~clk;

  int errors   = 0;
  int n_checks = 0;
  bit mon_en   = 1'b1;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // Reference model: accepted legal blocks, expected ack payloads, pending request, error.
  ent_t mdl[$];
  ent_t sb[$];
  bit   pending, m_err;
  int   m_n;
  bit   m_pop;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mdl.delete();
      sb.delete();
      pending = 1'b0;
      m_err   = 1'b0;
    end else if (mon_en) begin
      m_n   = mdl.size();
      m_pop = 1'b0;
      if (pending) begin
        if (m_n > 0) begin
          m_pop   = 1'b1;
          pending = 1'b0;
        end
      end else if (spawn_req) begin
        if (m_n > 0) m_pop = 1'b1;
        else         pending = 1'b1;
      end
      if (m_pop) sb.push_back(mdl.pop_front());
      if (gen_valid && m_n < QDEPTH) begin
        if (gen_shape > 4'd6) m_err = 1'b1;
        else mdl.push_back('{shape: gen_shape, rot: gen_rot, pos: gen_pos});
      end
    end
  end

  ent_t e;
  always @(negedge clk) begin
    if (mon_en) begin
      check("gen_ready", gen_ready, (!reset && mdl.size() < QDEPTH) ? 1 : 0);
      if (!reset) begin
        check("q_count", q_count, mdl.size());
        check("next_valid", next_valid, (mdl.size() > 0) ? 1 : 0);
        check("next_shape", next_shape, (mdl.size() > 0) ? mdl[0].shape : 0);
        check("err_shape", err_shape, m_err);
`ifndef HOLD_PIECE_EN
        check("hold_valid tied", hold_valid, 0);
        check("hold_shape tied", hold_shape, 0);
`endif
        if (spawn_ack || sb.size() > 0) begin
          if (sb.size() == 0) begin
            check("unexpected spawn_ack", spawn_ack, 0);
          end else begin
            e = sb.pop_front();
            check("spawn_ack", spawn_ack, 1);
            check("act_valid", act_valid, 1);
            check("act_shape", act_shape, e.shape);
            check("act_rot", act_rot, e.rot);
            check("act_pos", act_pos, e.pos);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, logic [3:0] s, bit sp, bit hr);
    gen_valid = v;
    gen_shape = s;
    gen_rot   = 2'($urandom);
    gen_pos   = 8'($urandom);
    spawn_req = sp;
    hold_req  = hr;
    step();
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_vals();
    check("rst act_valid", act_valid, 0);
    check("rst act_shape", act_shape, 0);
    check("rst act_rot", act_rot, 0);
    check("rst act_pos", act_pos, 128);
    check("rst spawn_ack", spawn_ack, 0);
    check("rst q_count", q_count, 0);
    check("rst next_valid", next_valid, 0);
    check("rst next_shape", next_shape, 0);
    check("rst hold_valid", hold_valid, 0);
    check("rst hold_shape", hold_shape, 0);
    check("rst err_shape", err_shape, 0);
    check("rst gen_ready", gen_ready, 0);
  endtask

  initial begin
    reset = 1'b1;
    gen_valid = 0; gen_shape = 0; gen_rot = 0; gen_pos = 0;
    spawn_req = 0; hold_req = 0;
    #2;
    check_reset_vals();
    step();
    step();
    reset = 1'b0;

    // Fill to depth; the fourth block must be held off.
    drive(1'b1, 4'd1, 1'b0, 1'b0);
    drive(1'b1, 4'd2, 1'b0, 1'b0);
    drive(1'b1, 4'd3, 1'b0, 1'b0);
    check("full gen_ready", gen_ready, 0);
    check("full q_count", q_count, 3);
    check("full next_shape", next_shape, 1);
    drive(1'b1, 4'd4, 1'b1, 1'b0);
    check("spawn act_shape", act_shape, 1);
    check("spawn ack", spawn_ack, 1);
    check("spawn q_count", q_count, 2);
    check("spawn next_shape", next_shape, 2);
    drive(1'b1, 4'd4, 1'b0, 1'b0);
    check("ack one cycle", spawn_ack, 0);
    check("refill q_count", q_count, 3);

    // Drain, then request on an empty queue.
    for (int i = 0; i < 3; i++) drive(1'b0, 4'd0, 1'b1, 1'b0);
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    check("empty spawn no ack", spawn_ack, 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("wait no ack", spawn_ack, 0);
    end
    drive(1'b1, 4'd5, 1'b0, 1'b0);
    check("wait push ack", spawn_ack, 0);
    check("wait push q_count", q_count, 1);
    idle();
    check("wait served ack", spawn_ack, 1);
    check("wait served shape", act_shape, 5);
    check("wait served q_count", q_count, 0);
    idle();
    check("wait ack one cycle", spawn_ack, 0);

    // Illegal shape: accepted, dropped, flagged.
    drive(1'b1, 4'd7, 1'b0, 1'b0);
    check("illegal q_count", q_count, 0);
    check("illegal err_shape", err_shape, 1);

    // Random traffic; many wraps of the pointers.
    for (int i = 0; i < 800; i++) begin
      bit v, sp, hr;
      v  = ($urandom_range(0, 9) < 6);
      sp = ($urandom_range(0, 3) == 0);
`ifdef HOLD_PIECE_EN
      hr = 1'b0;
`else
      hr = ($urandom_range(0, 4) == 0);
`endif
      drive(v, 4'($urandom_range(0, 7)), sp, hr);
    end
    check("err sticky", err_shape, 1);

    // Park a request in the wait state, then reset mid-cycle.
    for (int i = 0; i < 8; i++) drive(1'b0, 4'd0, 1'b1, 1'b0);
    idle();
    check("pre-reset q_count", q_count, 0);
    #3;
    reset = 1'b1;
    #1;
    check_reset_vals();
    step();
    reset = 1'b0;
    drive(1'b1, 4'd3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("lost request no ack", spawn_ack, 0);
    end
    check("lost request q_count", q_count, 1);

`ifdef HOLD_PIECE_EN
    mon_en = 1'b0;
    reset  = 1'b1;
    step();
    reset  = 1'b0;
    drive(1'b1, 4'd2, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    check("hold setup act", act_shape, 2);
    drive(1'b1, 4'd4, 1'b0, 1'b0);
    drive(1'b1, 4'd6, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    check("hold1 hold_shape", hold_shape, 2);
    check("hold1 hold_valid", hold_valid, 1);
    check("hold1 act_shape", act_shape, 4);
    check("hold1 ack", spawn_ack, 1);
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    check("hold2 ignored act", act_shape, 4);
    check("hold2 ignored ack", spawn_ack, 0);
    check("hold2 ignored hold", hold_shape, 2);
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    check("hold spawn act", act_shape, 6);
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    check("swap act_shape", act_shape, 2);
    check("swap act_rot", act_rot, 0);
    check("swap act_pos", act_pos, 128);
    check("swap hold_shape", hold_shape, 6);
    check("swap ack", spawn_ack, 1);
    reset = 1'b1;
    step();
    mon_en = 1'b1;
    reset  = 1'b0;
    idle();
`endif

    idle();
    idle();
    check("scoreboard drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
